// File: rtl/if_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared constants for the fetch and decode stages: word and
//               PC widths, the halt opcode, the NOP word and opcode field
//               position.
// Revision    : 1.0 - initial release
// ============================================================================
package if_stage_pkg;

    localparam int INSTR_W = 20;
    localparam int PC_W    = 4;

    // Opcode occupies the top nibble of the instruction word.
    localparam int OPC_MSB = 19;
    localparam int OPC_LSB = 16;

    localparam logic [OPC_MSB-OPC_LSB:0] HALT_OP   = 4'hF;
    localparam logic [INSTR_W-1:0]       NOP_INSTR = 20'h0_0000;

endpackage : if_stage_pkg
`default_nettype wire

// File: rtl/if_stage_instr_mem.sv
`default_nettype none
// ============================================================================
// Module      : instr_mem
// Description : Loadable instruction memory, 2**ADDR_W x DATA_W words.
//               Synchronous write, combinational read. A read and a write
//               to the same address in one cycle returns the old word.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_mem #(
    parameter int DATA_W = 20,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: contents are never reset so a loaded program survives rst.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    // Read port is asynchronous; the write lands after the edge, so the
    // fetch in the same cycle sees the previous contents.
    assign rdata = r_mem[raddr];

endmodule : instr_mem
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Holds the PC, the instruction memory
//               and the IF/ID register. Supports stall, branch redirect with
//               a bubble in the fetched slot, and a sticky halt on HALT_OP.
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter int INSTR_W = if_stage_pkg::INSTR_W,
    parameter int PC_W    = if_stage_pkg::PC_W,
    parameter logic [if_stage_pkg::OPC_MSB-if_stage_pkg::OPC_LSB:0] HALT_OP = if_stage_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [PC_W-1:0]    branch_target,
    input  logic               load_en,
    input  logic [PC_W-1:0]    load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               halted
);

    import if_stage_pkg::*;

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [PC_W-1:0]    r_pc_out;
    logic               r_valid;
    logic               r_halted;
    logic [INSTR_W-1:0] w_fetch;
    logic               w_is_halt;

    instr_mem #(
        .DATA_W (INSTR_W),
        .ADDR_W (PC_W)
    ) u_instr_mem (
        .clk   (clk),
        .we    (load_en),
        .waddr (load_addr),
        .wdata (load_data),
        .raddr (r_pc),
        .rdata (w_fetch)
    );

    assign w_is_halt = (w_fetch[OPC_MSB:OPC_LSB] == HALT_OP);

    // PC and IF/ID register; priority rst > halted > branch > stall > fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= '0;
            r_instr  <= INSTR_W'(NOP_INSTR);
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_halted <= 1'b0;
        end else if (r_halted) begin
            // Frozen: PC stays at HALT address+1, the slot drains to a bubble.
            r_instr  <= INSTR_W'(NOP_INSTR);
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else if (branch_en) begin
            // Redirect and flush the slot; the target word arrives next edge.
            r_pc     <= branch_target;
            r_instr  <= INSTR_W'(NOP_INSTR);
            r_pc_out <= '0;
            r_valid  <= 1'b0;
        end else if (!stall) begin
            r_instr  <= w_fetch;
            r_pc_out <= r_pc;
            r_valid  <= 1'b1;
            r_pc     <= r_pc + PC_W'(1);
            if (w_is_halt) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign instr_out = r_instr;
    assign pc_out    = r_pc_out;
    assign valid_out = r_valid;
    assign halted    = r_halted;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Directed, table-driven self-checking bench for if_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [3:0]  tgt;
        logic        ld;
        logic [3:0]  la;
        logic [19:0] ldata;
        logic [19:0] e_instr;
        logic [3:0]  e_pcout;
        logic        e_valid;
        logic        e_halted;
        logic [3:0]  e_pc;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_en = 1'b0;
    logic [3:0]  branch_target = '0;
    logic        load_en = 1'b0;
    logic [3:0]  load_addr = '0;
    logic [19:0] load_data = '0;
    logic [19:0] instr_out;
    logic [3:0]  pc_out;
    logic        valid_out;
    logic        halted;

    vec_t        tbl[$];
    logic [19:0] prog[16];
    int          n_vec  = 0;
    int          n_fail = 0;

    if_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .valid_out     (valid_out),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic s, input logic b, input logic [3:0] t,
                       input logic l, input logic [3:0] la, input logic [19:0] ld,
                       input logic [19:0] ei, input logic [3:0] ep, input logic ev,
                       input logic eh, input logic [3:0] epc);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.tgt = t;
        v.ld = l; v.la = la; v.ldata = ld;
        v.e_instr = ei; v.e_pcout = ep; v.e_valid = ev; v.e_halted = eh; v.e_pc = epc;
        tbl.push_back(v);
    endtask

    // Drive one vector on the falling edge, check one step after the rising edge.
    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        rst = v.rst; stall = v.stall; branch_en = v.br; branch_target = v.tgt;
        load_en = v.ld; load_addr = v.la; load_data = v.ldata;
        @(posedge clk);
        #1;
        n_vec++;
        if (instr_out !== v.e_instr || pc_out !== v.e_pcout || valid_out !== v.e_valid ||
            halted !== v.e_halted || dut.r_pc !== v.e_pc) begin
            n_fail++;
            $display("FAIL %s: got instr=%h pc_out=%h valid=%b halted=%b pc=%h, want instr=%h pc_out=%h valid=%b halted=%b pc=%h",
                     name, instr_out, pc_out, valid_out, halted, dut.r_pc,
                     v.e_instr, v.e_pcout, v.e_valid, v.e_halted, v.e_pc);
        end
    endtask

    initial begin
        vec_t hv;
        prog = '{20'h1_0102, 20'h2_0304, 20'h3_0506, 20'h4_0708,
                 20'h5_0909, 20'h6_0A0A, 20'h7_0B0B, 20'h8_0C0C,
                 20'h9_0D0D, 20'hA_0E0E, 20'h5_AABB, 20'h6_BBBB,
                 20'h7_CCCC, 20'h8_DDDD, 20'h9_EEEE, 20'h1_FFFF};

        // Load program while held in reset.
        for (int i = 0; i < 16; i++)
            add(1, 0, 0, 0, 1, 4'(i), prog[i], 0, 0, 0, 0, 0);
        // Sequential fetch.
        add(0, 0, 0, 0, 0, 0, 0, 20'h1_0102, 4'h0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 0, 0, 0, 20'h2_0304, 4'h1, 1, 0, 4'h2);
        // Stall two cycles.
        add(0, 1, 0, 0, 0, 0, 0, 20'h2_0304, 4'h1, 1, 0, 4'h2);
        add(0, 1, 0, 0, 0, 0, 0, 20'h2_0304, 4'h1, 1, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 0, 20'h3_0506, 4'h2, 1, 0, 4'h3);
        add(0, 0, 0, 0, 0, 0, 0, 20'h4_0708, 4'h3, 1, 0, 4'h4);
        // Branch with stall: branch wins, bubble, then target.
        add(0, 1, 1, 4'hA, 0, 0, 0, 20'h0, 4'h0, 0, 0, 4'hA);
        add(0, 0, 0, 0, 0, 0, 0, 20'h5_AABB, 4'hA, 1, 0, 4'hB);
        // Wrap-around; mem[0] reloaded to 20'h2_0000 along the way.
        add(0, 0, 1, 4'hE, 0, 0, 0, 20'h0, 4'h0, 0, 0, 4'hE);
        add(0, 0, 0, 0, 1, 4'h0, 20'h2_0000, 20'h9_EEEE, 4'hE, 1, 0, 4'hF);
        add(0, 0, 0, 0, 0, 0, 0, 20'h1_FFFF, 4'hF, 1, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0, 20'h2_0000, 4'h0, 1, 0, 4'h1);
        // Load/fetch collision returns the old word; refetch sees the new one.
        add(0, 0, 0, 0, 1, 4'h1, 20'h7_1234, 20'h2_0304, 4'h1, 1, 0, 4'h2);
        add(0, 0, 1, 4'h1, 0, 0, 0, 20'h0, 4'h0, 0, 0, 4'h1);
        add(0, 0, 0, 0, 0, 0, 0, 20'h7_1234, 4'h1, 1, 0, 4'h2);
        // Mid-run reset while planting a HALT at address 2.
        add(1, 0, 0, 0, 1, 4'h2, 20'hF_0000, 20'h0, 4'h0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0, 20'h2_0000, 4'h0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 0, 0, 0, 20'h7_1234, 4'h1, 1, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 0, 20'hF_0000, 4'h2, 1, 1, 4'h3);
        // Halted: branch and stall ignored, PC frozen at 3.
        add(0, 0, 1, 4'h5, 0, 0, 0, 20'h0, 4'h0, 0, 1, 4'h3);
        add(0, 1, 0, 0, 0, 0, 0, 20'h0, 4'h0, 0, 1, 4'h3);
        add(0, 0, 0, 0, 0, 0, 0, 20'h0, 4'h0, 0, 1, 4'h3);
        // Reset beats a simultaneous branch and clears halt.
        add(1, 0, 1, 4'h5, 0, 0, 0, 20'h0, 4'h0, 0, 0, 4'h0);
        add(0, 0, 0, 0, 0, 0, 0, 20'h2_0000, 4'h0, 1, 0, 4'h1);
        add(0, 0, 0, 0, 0, 0, 0, 20'h7_1234, 4'h1, 1, 0, 4'h2);
        // Stall while the HALT word is presented: no fetch, no halt.
        add(0, 1, 0, 0, 0, 0, 0, 20'h7_1234, 4'h1, 1, 0, 4'h2);
        add(0, 1, 0, 0, 0, 0, 0, 20'h7_1234, 4'h1, 1, 0, 4'h2);
        add(0, 0, 0, 0, 0, 0, 0, 20'hF_0000, 4'h2, 1, 1, 4'h3);

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Hand sequence: stall held from the first cycle after reset keeps the
        // reset bubble; the first fetch follows release of stall.
        hv = '{rst:1, stall:0, br:0, tgt:0, ld:0, la:0, ldata:0,
               e_instr:0, e_pcout:0, e_valid:0, e_halted:0, e_pc:0};
        apply(hv, "rst_again");
        hv.rst = 0; hv.stall = 1;
        apply(hv, "stall_after_rst_1");
        apply(hv, "stall_after_rst_2");
        hv.stall = 0; hv.e_instr = 20'h2_0000; hv.e_valid = 1; hv.e_pc = 4'h1;
        apply(hv, "first_fetch_after_stall");

        // Hand sequence: a load while halted still updates memory.
        hv = '{rst:0, stall:0, br:0, tgt:0, ld:0, la:0, ldata:0,
               e_instr:20'h7_1234, e_pcout:4'h1, e_valid:1, e_halted:0, e_pc:4'h2};
        apply(hv, "fetch_pc1");
        hv.e_instr = 20'hF_0000; hv.e_pcout = 4'h2; hv.e_halted = 1; hv.e_pc = 4'h3;
        apply(hv, "halt_again");
        hv.ld = 1; hv.la = 4'h2; hv.ldata = 20'h3_3333;
        hv.e_instr = 0; hv.e_pcout = 0; hv.e_valid = 0;
        apply(hv, "load_while_halted");
        hv.ld = 0; hv.rst = 1; hv.e_halted = 0; hv.e_pc = 0;
        apply(hv, "rst_clear");
        hv.rst = 0; hv.br = 1; hv.tgt = 4'h2; hv.e_pc = 4'h2;
        apply(hv, "branch_to_2");
        hv.br = 0; hv.e_instr = 20'h3_3333; hv.e_pcout = 4'h2; hv.e_valid = 1; hv.e_pc = 4'h3;
        apply(hv, "fetch_reloaded");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule : tb_if_stage
`default_nettype wire
